sel_encoder: RTL and testbench

SEL_ENCODER -- requirements
Module: sel_encoder

---
 rtl/sel_encoder.sv | 75 +++++++
 tb/tb_sel_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sel_encoder.sv
// Single-entry registered encoder from a 4-bit code to a 2-bit select, with a valid/ready handshake on both sides.
// Define SEL_ENCODER_ERRCNT_EN to build the saturating counter of unencodable codes; otherwise err_count is tied to 0.
module sel_encoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       sel,
  output logic             code_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state, state_next;
  logic       accept_evt, release_evt;
  logic [1:0] enc_sel;
  logic       enc_err;

  always_comb begin
    in_ready    = (state == EMPTY) || out_ready;
    accept_evt  = in_valid && in_ready;
    release_evt = (state == FULL) && out_ready;
    enc_sel     = 2'd0;
    enc_err     = 1'b1;
    if (data_in[3:2] == 2'b00) begin
      enc_sel = data_in[1:0];
      enc_err = 1'b0;
    end
    state_next = state;
    if (accept_evt) begin
      state_next = FULL;
    end else if (release_evt) begin
      state_next = EMPTY;
    end
  end

  // The result registers are cleared on release so they read 0 whenever the entry is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      sel      <= 2'd0;
      code_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept_evt) begin
        sel      <= enc_sel;
        code_err <= enc_err;
      end else if (release_evt) begin
        sel      <= 2'd0;
        code_err <= 1'b0;
      end
    end
  end

  assign out_valid = (state == FULL);

`ifdef SEL_ENCODER_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (accept_evt && enc_err && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sel_encoder.sv
// Self-checking bench for sel_encoder: directed scenarios plus a randomized run against a behavioural model.
module tb_sel_encoder;

  logic       clk;
  logic       reset;
  logic [3:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic       code_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] err_count;

  logic [3:0] data_in2;
  logic       in_valid2;
  logic       in_ready2;
  logic [1:0] sel2;
  logic       code_err2;
  logic       out_valid2;
  logic       out_ready2;
  logic [1:0] err_count2;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the single output slot and the error tally.
  bit m_full;
  int m_sel;
  int m_err;
  int m_cnt;

  sel_encoder #(.ERR_W(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .code_err(code_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  sel_encoder #(.ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .data_in(data_in2), .in_valid(in_valid2),
    .in_ready(in_ready2), .sel(sel2), .code_err(code_err2),
    .out_valid(out_valid2), .out_ready(out_ready2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int expCount(input int raw, input int width);
`ifdef SEL_ENCODER_ERRCNT_EN
    int maxv;
    maxv = (1 << width) - 1;
    return (raw > maxv) ? maxv : raw;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    m_full = 0;
    m_sel  = 0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  // One cycle: drive at negedge, check ready, advance the model, check registered outputs after the edge.
  task automatic applyStimulus(input int d, input bit iv, input bit ordy, input string tag);
    bit exp_ready, acc, rel;
    @(negedge clk);
    data_in   = 4'(d);
    in_valid  = iv;
    out_ready = ordy;
    #1;
    exp_ready = !m_full || ordy;
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    acc = iv && exp_ready;
    rel = m_full && ordy;
    if (acc) begin
      m_full = 1;
      if (d < 4) begin
        m_sel = d;
        m_err = 0;
      end else begin
        m_sel = 0;
        m_err = 1;
        m_cnt++;
      end
    end else if (rel) begin
      m_full = 0;
      m_sel  = 0;
      m_err  = 0;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(m_full));
    checkOutput({tag, ".sel"}, 32'(sel), 32'(m_sel));
    checkOutput({tag, ".code_err"}, 32'(code_err), 32'(m_err));
    checkOutput({tag, ".err_count"}, 32'(err_count), 32'(expCount(m_cnt, 8)));
  endtask

  initial begin
    reset      = 1'b0;
    data_in    = 4'd0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    data_in2   = 4'd0;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    modelReset();

    #12;
    checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.sel", 32'(sel), 32'd0);
    checkOutput("rst.err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // First accept right after reset release, then a back-to-back stream.
    applyStimulus(2, 1, 1, "first");
    checkOutput("first.sel2", 32'(sel), 32'd2);
    for (int i = 0; i < 4; i++) applyStimulus(i, 1, 1, "stream");
    applyStimulus(0, 0, 1, "drain");

    // Stall: accept 3, hold three cycles with 1 pending, then release.
    applyStimulus(3, 1, 0, "stall.acc");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, "stall.hold");
    checkOutput("stall.sel3", 32'(sel), 32'd3);
    applyStimulus(1, 1, 1, "stall.swap");
    checkOutput("stall.sel1", 32'(sel), 32'd1);
    applyStimulus(0, 0, 1, "stall.drain");

    // Unencodable codes.
    applyStimulus(4, 1, 1, "bad4");
    applyStimulus(9, 1, 1, "bad9");
    applyStimulus(15, 1, 1, "bad15");
    applyStimulus(0, 0, 1, "bad.drain");
    checkOutput("bad.count", 32'(err_count), 32'(expCount(3, 8)));

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(int'($urandom_range(15, 0)), bit'($urandom_range(1, 0)),
                    bit'($urandom_range(3, 0) != 0), "rand");
    end

    // Saturation on the narrow instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_in2  = 4'(4 + i);
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("sat.code_err", 32'(code_err2), 32'd1);
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    checkOutput("sat.err_count", 32'(err_count2), 32'(expCount(5, 2)));

    // Asynchronous reset in the middle of a stall.
    applyStimulus(13, 1, 0, "mid.acc");
    applyStimulus(2, 1, 0, "mid.hold");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("mid.out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid.sel", 32'(sel), 32'd0);
    checkOutput("mid.code_err", 32'(code_err), 32'd0);
    checkOutput("mid.err_count", 32'(err_count), 32'd0);
    checkOutput("mid.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 1, 1, "post");
    applyStimulus(0, 0, 1, "post.drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
